// File: rtl/font_pkg.sv
// Shared font-ROM constants: glyph geometry, ROM address width and requester ids.
package font_pkg;
  localparam int CHAR_W      = 7;
  localparam int ROW_W       = 4;
  localparam int DATA_W      = 8;
  localparam int ADDR_W      = CHAR_W + ROW_W;
  localparam int REQ_TEXT    = 0;
  localparam int REQ_PRICE   = 1;
  localparam int NUM_REQ_DEF = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr_i and wraps; next_ptr_o points just past the winner.
module rr_arbiter
  import font_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   next_ptr_o
);

  logic             found_s;
  logic [PTR_W-1:0] cand_s;
  int               sum_s;

  // First asserted request at or after the pointer wins; no request leaves the pointer alone.
  always_comb begin
    grant_o    = {NUM_REQ{1'b0}};
    next_ptr_o = ptr_i;
    found_s    = 1'b0;
    cand_s     = {PTR_W{1'b0}};
    sum_s      = 32'sd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s  = int'(ptr_i) + k;
      sum_s  = (sum_s >= NUM_REQ) ? (sum_s - NUM_REQ) : sum_s;
      cand_s = PTR_W'(sum_s);
      if (!found_s && req_i[cand_s]) begin
        grant_o[cand_s] = 1'b1;
        found_s         = 1'b1;
        next_ptr_o      = (sum_s == NUM_REQ - 1) ? {PTR_W{1'b0}} : PTR_W'(sum_s + 32'sd1);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM between several glyph-row readers: grant, address,
// then a two-stage tag pipeline steers the returning ROM word into the winner's slice.
module font_rom_arbiter #(
  parameter int NUM_REQ = font_pkg::NUM_REQ_DEF,
  parameter int CHAR_W  = font_pkg::CHAR_W,
  parameter int ROW_W   = font_pkg::ROW_W,
  parameter int DATA_W  = font_pkg::DATA_W
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*CHAR_W-1:0]   char_code,
  input  logic [NUM_REQ*ROW_W-1:0]    row_sel,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [CHAR_W+ROW_W-1:0]     rom_addr,
  input  logic [DATA_W-1:0]           rom_data,
  output logic [NUM_REQ-1:0]          rd_valid,
  output logic [NUM_REQ*DATA_W-1:0]   rd_data
);

  localparam int ADDR_W = CHAR_W + ROW_W;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]          ptr_q, ptr_d, next_ptr_s;
  logic [NUM_REQ-1:0]        grant_s, gnt_q, gnt_d, tag_q, tag_d, rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]         sel_addr_s, rom_addr_q, rom_addr_d;
  logic [NUM_REQ*DATA_W-1:0] rd_data_q, rd_data_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i      (req),
    .ptr_i      (ptr_q),
    .grant_o    (grant_s),
    .next_ptr_o (next_ptr_s)
  );

  // Select the winner's {char, row}; the grant is one-hot so a masked OR is a mux.
  always_comb begin
    sel_addr_s = {ADDR_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s = sel_addr_s | ({ADDR_W{grant_s[i]}} &
                   {char_code[i*CHAR_W +: CHAR_W], row_sel[i*ROW_W +: ROW_W]});
    end
  end

  // Next state: tag follows gnt by one cycle, rd_valid follows tag, data lands with rd_valid.
  always_comb begin
    gnt_d      = grant_s;
    ptr_d      = next_ptr_s;
    tag_d      = gnt_q;
    rd_valid_d = tag_q;
    rd_data_d  = rd_data_q;
    if (|grant_s) begin
      rom_addr_d = sel_addr_s;
    end else begin
      rom_addr_d = rom_addr_q;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_q[i]) begin
        rd_data_d[i*DATA_W +: DATA_W] = rom_data;
      end else begin
        rd_data_d[i*DATA_W +: DATA_W] = rd_data_q[i*DATA_W +: DATA_W];
      end
    end
  end

  // State registers; reset drops any read still in the tag pipeline.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q      <= {PTR_W{1'b0}};
      gnt_q      <= {NUM_REQ{1'b0}};
      tag_q      <= {NUM_REQ{1'b0}};
      rd_valid_q <= {NUM_REQ{1'b0}};
      rom_addr_q <= {ADDR_W{1'b0}};
      rd_data_q  <= {(NUM_REQ*DATA_W){1'b0}};
    end else begin
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      tag_q      <= tag_d;
      rd_valid_q <= rd_valid_d;
      rom_addr_q <= rom_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign gnt      = gnt_q;
  assign rom_addr = rom_addr_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Scoreboard bench for font_rom_arbiter: directed scenarios plus random traffic,
// checked against a cycle-level reference model of grants and ROM returns.
module tb_font_rom_arbiter;
  localparam int N  = 2;
  localparam int CW = 7;
  localparam int RW = 4;
  localparam int DW = 8;
  localparam int AW = CW + RW;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    req;
  logic [N*CW-1:0] char_code;
  logic [N*RW-1:0] row_sel;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic [N-1:0]    rd_valid;
  logic [N*DW-1:0] rd_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    int            due;
  } rd_item_t;

  logic [N-1:0]  gnt_exp_q[$];
  rd_item_t      rd_q[$];
  logic [AW-1:0] exp_addr;
  logic          rst_edge = 1'b0;

  font_rom_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .char_code (char_code),
    .row_sel   (row_sel),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    logic [31:0] t;
    t = {21'd0, a} * 32'd73 + 32'd29;
    return t[7:0] ^ t[15:8];
  endfunction

  // External synchronous font ROM.
  always @(posedge CLK) rom_data <= rom_fn(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] rq,
                       input logic [CW-1:0] c0, input logic [RW-1:0] w0,
                       input logic [CW-1:0] c1, input logic [RW-1:0] w1);
    RST       = r;
    req       = rq;
    char_code = {c1, c0};
    row_sel   = {w1, w0};
    @(posedge CLK);
    #1;
  endtask

  // Reference model: remembers who was granted last and searches onward from there.
  initial begin : model
    int           last;
    int           start;
    int           c;
    logic [N-1:0] g;
    rd_item_t     it;
    last     = N - 1;
    exp_addr = '0;
    forever begin
      @(posedge CLK);
      cyc++;
      rst_edge = RST;
      g        = '0;
      if (RST) begin
        last     = N - 1;
        exp_addr = '0;
        rd_q.delete();
      end else begin
        start = last;
        for (int k = 1; k <= N; k++) begin
          c = (start + k) % N;
          if (g == '0 && ((req >> c) & N'(1)) != '0) begin
            g        = N'(1) << c;
            last     = c;
            exp_addr = {char_code[c*CW +: CW], row_sel[c*RW +: RW]};
            it.idx   = c;
            it.addr  = exp_addr;
            it.due   = cyc + 2;
            rd_q.push_back(it);
          end
        end
      end
      gnt_exp_q.push_back(g);
    end
  end

  // Monitor: compares the DUT against the model on the falling edge.
  initial begin : monitor
    logic [N-1:0]    e;
    logic [N-1:0]    ev;
    logic [N*DW-1:0] shadow;
    rd_item_t        it;
    shadow = '0;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      if (gnt_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL gnt_queue: no expectation queued (cycle %0d)", cyc);
      end else begin
        e = gnt_exp_q.pop_front();
        check("gnt", 32'(gnt), 32'(e));
      end
      check("rom_addr", 32'(rom_addr), 32'(exp_addr));
      if (rst_edge) shadow = '0;
      ev = '0;
      if (rd_q.size() > 0 && (rd_q[0].due == cyc || rd_valid != '0)) begin
        if (rd_q[0].due == cyc) begin
          it = rd_q.pop_front();
          ev = N'(1) << it.idx;
          shadow[it.idx*DW +: DW] = rom_fn(it.addr);
        end
      end
      check("rd_valid", 32'(rd_valid), 32'(ev));
      check("rd_data", 32'(rd_data), 32'(shadow));
    end
  end

  initial begin : stim
    RST = 1'b1; req = '0; char_code = '0; row_sel = '0;
    drive(1'b1, 2'b00, 7'h00, 4'h0, 7'h00, 4'h0);
    drive(1'b1, 2'b00, 7'h00, 4'h0, 7'h00, 4'h0);

    // single request from the text writer
    drive(1'b0, 2'b01, 7'h41, 4'h3, 7'h00, 4'h0);
    check("first_gnt", 32'(gnt), 32'h1);
    check("addr_413", 32'(rom_addr), 32'h413);
    drive(1'b0, 2'b00, 7'h00, 4'h0, 7'h00, 4'h0);
    drive(1'b0, 2'b00, 7'h00, 4'h0, 7'h00, 4'h0);
    check("first_rd", 32'(rd_data[7:0]), 32'(rom_fn(11'h413)));
    drive(1'b0, 2'b00, 7'h00, 4'h0, 7'h00, 4'h0);

    // contention from a fresh pointer: alternation 01,10,...
    drive(1'b1, 2'b00, 7'h00, 4'h0, 7'h00, 4'h0);
    for (int i = 0; i < 6; i++)
      drive(1'b0, 2'b11, 7'($urandom), 4'($urandom), 7'($urandom), 4'($urandom));
    drive(1'b0, 2'b00, 7'h00, 4'h0, 7'h00, 4'h0);
    drive(1'b0, 2'b00, 7'h00, 4'h0, 7'h00, 4'h0);

    // streaming: price writer alone, every row of one glyph
    for (int r = 0; r < 16; r++)
      drive(1'b0, 2'b10, 7'($urandom), 4'($urandom), 7'h2A, 4'(r));
    drive(1'b0, 2'b00, 7'h00, 4'h0, 7'h00, 4'h0);
    drive(1'b0, 2'b00, 7'h00, 4'h0, 7'h00, 4'h0);

    // reset one cycle after a grant: the read is dropped, requests ignored
    drive(1'b0, 2'b01, 7'h55, 4'h9, 7'h00, 4'h0);
    drive(1'b1, 2'b11, 7'h12, 4'h1, 7'h34, 4'h2);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_data", 32'(rd_data), 32'h0);
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 7'h00, 4'h0, 7'h00, 4'h0);

    // withdrawal of req[1] while req[0] wins, then idle holds rom_addr
    drive(1'b0, 2'b11, 7'h61, 4'h5, 7'h62, 4'h6);
    drive(1'b0, 2'b01, 7'h63, 4'h7, 7'h62, 4'h6);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'b00, 7'h00, 4'h0, 7'h00, 4'h0);
    check("idle_addr", 32'(rom_addr), 32'({7'h63, 4'h7}));

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)),
            7'($urandom), 4'($urandom), 7'($urandom), 4'($urandom));

    for (int i = 0; i < 4; i++) drive(1'b0, 2'b00, 7'h00, 4'h0, 7'h00, 4'h0);
    check("drain", 32'(rd_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
